reg_dump_tx: RTL and testbench
==============================

REG_DUMP_TX -- requirements
Module: reg_dump_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter HEADER, default 8'hA5, giving the sync byte sent before each dump.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  request one full dump; sampled only in IDLE.
REQ-007 SHALL have port reg_data_selected  input  16  register-file data for reg_select (combinational, same cycle).
REQ-008 SHALL have port reg_select  output  3  register index presented to the register file.
REQ-009 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-010 SHALL have port busy  output  1  high from the cycle after accepted start until the return to IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse when the last stop bit completes.

Function
REQ-012 SHALL use top FSM states IDLE, HDR, LOAD, SEND_HI, SEND_LO, FIN.
REQ-013 IDLE: on start=1 SHALL go to HDR with idx=0; otherwise remain; start while not IDLE SHALL be ignored.
REQ-014 HDR: SHALL send HEADER, then go to LOAD.
REQ-015 LOAD: SHALL drive reg_select=idx for exactly one cycle and capture reg_data_selected into a 16-bit snapshot at the end of that cycle, then go to SEND_HI.
REQ-016 SEND_HI: SHALL send snapshot[15:8]; SEND_LO: SHALL send snapshot[7:0].
REQ-017 After SEND_LO: if idx==7, SHALL go to FIN, else idx<=idx+1 and go to LOAD; idx SHALL NOT wrap.
REQ-018 FIN: SHALL assert done for one cycle and return to IDLE; busy SHALL deassert in the same cycle.
REQ-019 A dump SHALL be exactly 17 bytes: HEADER, then R0..R7, each sent high byte first.
REQ-020 R0 SHALL be sent as read through reg_data_selected (0x0000 from a compliant register file); no special-casing inside this block.
REQ-021 Each byte SHALL be framed as start bit (0), 8 data bits LSB first, stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-022 Consecutive bytes SHALL be back-to-back except one LOAD cycle (tx high) before each SEND_HI; no other idle gaps.
REQ-023 The snapshot SHALL be immune to register-file writes after its LOAD cycle.
REQ-024 reg_select SHALL hold its last driven value outside LOAD.

Reset
REQ-025 rst SHALL take priority over all other inputs and abort any in-progress byte or dump immediately.
REQ-026 After reset: state=IDLE, tx=1, busy=0, done=0, reg_select=0, idx=0, snapshot=0, bit/baud counters=0.
REQ-027 Reset mid-byte SHALL force tx high the following cycle; no partial frame completion and no done pulse.

Structure
REQ-028 SHALL place FSM state encoding, the default CLKS_PER_BIT, and the default HEADER in a shared package alongside other project constants.
REQ-029 SHALL instantiate one sub-module uart_tx_byte.
REQ-030 uart_tx_byte SHALL have ports clk, rst, data[7:0], valid, ready, tx.
REQ-031 uart_tx_byte SHALL accept data when valid&&ready and hold ready low until its stop bit ends.
REQ-032 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-033 Reset check: assert rst during a byte -> next cycle tx=1, busy=0, done=0, no further edges on tx.
REQ-034 Full dump: regs R1..R7 = 16'h1111..16'h7777, R0=0, pulse start -> decoded bytes A5 00 00 11 11 22 22 ... 77 77, done once after 170 bit-times plus 8 LOAD cycles.
REQ-035 Snapshot: write R3=16'hBEEF after R3 LOAD but before SEND_LO -> dump shows 33 33 for R3; next dump shows BE EF.
REQ-036 Busy start: pulse start mid-dump -> no second dump, exactly one done.
REQ-037 Bit timing with CLKS_PER_BIT=2: every tx level holds exactly 2 cycles; bits of byte 8'h01 serialize as 0,1,0,0,0,0,0,0,0,1.
REQ-038 Back-to-back: start asserted the cycle done pulses, then held -> second dump begins with HEADER one cycle after IDLE is entered.

Source files
------------

// File: rtl/reg_dump_tx_pkg.sv
// Shared constants and state encoding for the register dump transmitter.
//   DEF_CLKS_PER_BIT : default clk cycles per UART bit
//   DEF_HEADER       : default sync byte sent ahead of each dump
//   LAST_IDX         : index of the last register in a dump
//   STOP_BIT_IDX     : frame position of the stop bit (start=0, data=1..8)
//   state_t          : top-level dump FSM states
package reg_dump_tx_pkg;

    localparam int         DEF_CLKS_PER_BIT = 434;
    localparam logic [7:0] DEF_HEADER       = 8'hA5;
    localparam logic [2:0] LAST_IDX         = 3'd7;
    localparam logic [3:0] STOP_BIT_IDX     = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        SEND_HI,
        SEND_LO,
        FIN
    } state_t;

endpackage

// File: rtl/reg_dump_tx_uart_tx_byte.sv
// 8N1 UART byte serializer.
//   clk   : system clock
//   rst   : synchronous active-high reset, forces tx high
//   data  : byte to send, taken when valid && ready
//   valid : byte offered
//   ready : may accept a byte; also high during the final stop-bit cycle so
//           the next frame can start with no idle gap
//   tx    : serial line, idle high
module uart_tx_byte
    import reg_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    logic              active_q, active_d;
    logic [8:0]        shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              tx_q, tx_d;
    logic              last_tick;

    assign last_tick = active_q && (baud_q == '0) && (bit_q == STOP_BIT_IDX);
    assign ready     = !active_q || last_tick;
    assign tx        = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            shift_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
        end
    end

    // shift_q holds the bits still to go after the one on the line; a 1 is
    // shifted in from the top so the stop bit falls out after data[7].
    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        tx_d     = tx_q;
        if (valid && ready) begin
            active_d = 1'b1;
            shift_d  = {1'b1, data};
            bit_d    = '0;
            baud_d   = BAUD_RELOAD;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_q == '0) begin
                if (bit_q == STOP_BIT_IDX) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                    baud_d  = BAUD_RELOAD;
                end
            end else begin
                baud_d = baud_q - BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Dumps eight 16-bit registers over UART: HEADER, then R0..R7 high byte first.
//   clk               : system clock
//   rst               : synchronous active-high reset, aborts any dump
//   start             : request a dump, only looked at in IDLE
//   reg_data_selected : register-file read data for reg_select
//   reg_select        : register index, updated on entry to LOAD and held
//   tx                : UART line, 8N1, idle high
//   busy              : dump in progress
//   done              : one-cycle pulse after the last stop bit
//
// state   | meaning
// IDLE    | waiting for start; launches HEADER when start is seen
// HDR     | HEADER on the line
// LOAD    | reg_select=idx, snapshot captured, high byte launched
// SEND_HI | high byte on the line; low byte launched at its stop end
// SEND_LO | low byte on the line
// FIN     | done pulse, back to IDLE
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [7:0] HEADER       = DEF_HEADER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] reg_data_selected,
    output logic [2:0]  reg_select,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  sel_q, sel_d;
    logic [15:0] snap_q, snap_d;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;

    assign reg_select = sel_q;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .data  (byte_data),
        .valid (byte_valid),
        .ready (byte_ready),
        .tx    (tx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
        end
    end

    // Each byte is handed to the serializer on the edge that leaves the
    // previous state, so the line never idles except for the LOAD cycle.
    // In LOAD the high byte comes from the same read data being captured
    // into the snapshot on that edge, so it equals snap_q[15:8].
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        snap_d     = snap_q;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_valid = 1'b1;
                    byte_data  = HEADER;
                    if (byte_ready) begin
                        idx_d   = '0;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                busy = 1'b1;
                if (byte_ready) begin
                    sel_d   = idx_q;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                snap_d     = reg_data_selected;
                byte_valid = 1'b1;
                byte_data  = reg_data_selected[15:8];
                if (byte_ready) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                busy = 1'b1;
                if (byte_ready) begin
                    byte_valid = 1'b1;
                    byte_data  = snap_q[7:0];
                    state_d    = SEND_LO;
                end
            end
            SEND_LO: begin
                busy = 1'b1;
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        sel_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
module tb_reg_dump_tx;

    localparam int C  = 4;
    localparam int C2 = 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] reg_data_selected;
    logic [2:0]  reg_select;
    logic        tx, busy, done;
    logic        rst2, start2;
    logic [15:0] rd2;
    logic [2:0]  rs2;
    logic        tx2, busy2, done2;

    logic [15:0] regs [8];
    assign reg_data_selected = regs[reg_select];
    assign rd2               = regs[rs2];

    always #5 clk = ~clk;

    reg_dump_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .reg_data_selected(reg_data_selected),
        .reg_select(reg_select), .tx(tx), .busy(busy), .done(done)
    );

    reg_dump_tx #(.CLKS_PER_BIT(C2), .HEADER(8'h01)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .reg_data_selected(rd2),
        .reg_select(rs2), .tx(tx2), .busy(busy2), .done(done2)
    );

    int n_vec = 0;
    int n_err = 0;

    // cycle counter, updated on posedge so it is stable at every negedge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART decoder / done counter for dut (CLKS_PER_BIT=4)
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          frame_err = 0;
    logic        rx_active = 1'b0;
    int          rx_k      = 0;
    int          rx_b;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_q [$];
    int          rx_cyc_q [$];

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rst !== 1'b0) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_k      = 0;
                    rx_cyc_q.push_back(cyc);
                end
            end else begin
                rx_k++;
                if (rx_k % C == C / 2) begin
                    rx_b = rx_k / C;
                    if (rx_b == 0) begin
                        if (tx !== 1'b0) frame_err++;
                    end else if (rx_b <= 8) begin
                        rx_byte[rx_b-1] = tx;
                    end else begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(rx_byte);
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_dump [17];

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_regs();
        for (int r = 0; r < 8; r++) regs[r] = 16'(r * 16'h1111);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (reg_select !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", reg_select); end
        n_vec++; if (tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            n_err++; $display("FAIL reset_dut2: tx=%b busy=%b done=%b want 1 0 0", tx2, busy2, done2);
        end
        rst = 1'b0; rst2 = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (tx !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: tx=%b busy=%b want 1 0", tx, busy);
        end
    endtask

    task automatic test_full_dump();
        int rb, db, fb;
        bit ok;
        set_regs();
        rb = rx_q.size(); db = done_cnt; fb = frame_err;
        pulse_start();
        n_vec++; if (busy !== 1'b1 || tx !== 1'b0) begin
            n_err++; $display("FAIL dump_begin: busy=%b tx=%b want 1 0", busy, tx);
        end
        wait_done(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL dump_done_timeout: no done within 2000 cycles"); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_width: got %b want 0", done); end
        repeat (10) @(negedge clk);
        n_vec++; if (rx_q.size() - rb != 17) begin
            n_err++; $display("FAIL dump_len: got %0d want 17", rx_q.size() - rb);
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_vec++; if (rx_q[rb+i] !== exp_dump[i]) begin
                    n_err++; $display("FAIL dump_byte%0d: got %h want %h", i, rx_q[rb+i], exp_dump[i]);
                end
            end
            n_vec++; if (done_cyc - rx_cyc_q[rb] != 170 * C + 8) begin
                n_err++; $display("FAIL dump_duration: got %0d want %0d", done_cyc - rx_cyc_q[rb], 170 * C + 8);
            end
            n_vec++; if (rx_cyc_q[rb+1] - rx_cyc_q[rb] != 10 * C + 1) begin
                n_err++; $display("FAIL load_gap: got %0d want %0d", rx_cyc_q[rb+1] - rx_cyc_q[rb], 10 * C + 1);
            end
            n_vec++; if (rx_cyc_q[rb+2] - rx_cyc_q[rb+1] != 10 * C) begin
                n_err++; $display("FAIL hi_lo_gap: got %0d want %0d", rx_cyc_q[rb+2] - rx_cyc_q[rb+1], 10 * C);
            end
        end
        n_vec++; if (done_cnt - db != 1) begin n_err++; $display("FAIL dump_done_count: got %0d want 1", done_cnt - db); end
        n_vec++; if (frame_err != fb) begin n_err++; $display("FAIL framing: got %0d errors want 0", frame_err - fb); end
        n_vec++; if (reg_select !== 3'd7) begin n_err++; $display("FAIL sel_hold: got %0d want 7", reg_select); end
    endtask

    task automatic test_snapshot();
        int rb;
        bit ok, found;
        set_regs();
        rb = rx_q.size();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (reg_select === 3'd3) found = 1'b1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL snap_load_timeout: reg_select never 3"); end
        @(posedge clk);
        #1 regs[3] = 16'hBEEF;
        wait_done(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL snap_done_timeout: no done within 2000 cycles"); end
        repeat (10) @(negedge clk);
        n_vec++; if (rx_q.size() - rb != 17) begin
            n_err++; $display("FAIL snap_len: got %0d want 17", rx_q.size() - rb);
        end else begin
            n_vec++; if (rx_q[rb+7] !== 8'h33 || rx_q[rb+8] !== 8'h33) begin
                n_err++; $display("FAIL snap_r3: got %h %h want 33 33", rx_q[rb+7], rx_q[rb+8]);
            end
            n_vec++; if (rx_q[rb+9] !== 8'h44) begin n_err++; $display("FAIL snap_r4: got %h want 44", rx_q[rb+9]); end
        end
        rb = rx_q.size();
        pulse_start();
        wait_done(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL snap2_done_timeout: no done within 2000 cycles"); end
        repeat (10) @(negedge clk);
        n_vec++; if (rx_q.size() - rb != 17) begin
            n_err++; $display("FAIL snap2_len: got %0d want 17", rx_q.size() - rb);
        end else begin
            n_vec++; if (rx_q[rb+7] !== 8'hBE || rx_q[rb+8] !== 8'hEF) begin
                n_err++; $display("FAIL snap2_r3: got %h %h want be ef", rx_q[rb+7], rx_q[rb+8]);
            end
        end
        regs[3] = 16'h3333;
    endtask

    task automatic test_busy_start();
        int rb, db;
        bit ok;
        rb = rx_q.size(); db = done_cnt;
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_done(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL busy_done_timeout: no done within 2000 cycles"); end
        repeat (300) @(negedge clk);
        n_vec++; if (done_cnt - db != 1) begin n_err++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - db); end
        n_vec++; if (rx_q.size() - rb != 17) begin n_err++; $display("FAIL busy_len: got %0d want 17", rx_q.size() - rb); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int rb, db, done_at;
        bit ok;
        rb = rx_q.size(); db = done_cnt;
        pulse_start();
        wait_done(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_done_timeout: no done within 2000 cycles"); end
        done_at = cyc;
        start = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: busy got %b want 0", busy); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b1 || tx !== 1'b0) begin
            n_err++; $display("FAIL b2b_restart: busy=%b tx=%b want 1 0", busy, tx);
        end
        start = 1'b0;
        wait_done(2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_done2_timeout: no done within 2000 cycles"); end
        repeat (50) @(negedge clk);
        n_vec++; if (rx_q.size() - rb != 34) begin
            n_err++; $display("FAIL b2b_len: got %0d want 34", rx_q.size() - rb);
        end else begin
            n_vec++; if (rx_q[rb+17] !== 8'hA5) begin n_err++; $display("FAIL b2b_header: got %h want a5", rx_q[rb+17]); end
            n_vec++; if (rx_cyc_q[rb+17] - done_at != 2) begin
                n_err++; $display("FAIL b2b_latency: got %0d want 2", rx_cyc_q[rb+17] - done_at);
            end
        end
        n_vec++; if (done_cnt - db != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - db); end
    endtask

    task automatic test_bit_timing();
        logic [9:0] pat;
        pat = 10'b10_0000_0010;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_vec++; if (tx2 !== pat[i/2]) begin
                n_err++; $display("FAIL bit_timing_c%0d: got %b want %b", i, tx2, pat[i/2]);
            end
            @(negedge clk);
        end
        n_vec++; if (tx2 !== 1'b1 || rs2 !== 3'd0) begin
            n_err++; $display("FAIL bit_timing_load: tx=%b sel=%0d want 1 0", tx2, rs2);
        end
        @(negedge clk);
        n_vec++; if (tx2 !== 1'b0) begin n_err++; $display("FAIL bit_timing_hi_start: got %b want 0", tx2); end
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
    endtask

    task automatic test_reset_midbyte();
        int rb, db, edges;
        logic prev;
        rb = rx_q.size(); db = done_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        n_vec++; if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL midbyte_pre: tx=%b busy=%b want 0 1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midbyte_reset: tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
        end
        rst = 1'b0;
        edges = 0;
        prev = tx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== prev) edges++;
            prev = tx;
        end
        n_vec++; if (edges != 0) begin n_err++; $display("FAIL midbyte_edges: got %0d want 0", edges); end
        n_vec++; if (done_cnt != db) begin n_err++; $display("FAIL midbyte_done: got %0d pulses want 0", done_cnt - db); end
        n_vec++; if (rx_q.size() - rb != 1) begin n_err++; $display("FAIL midbyte_bytes: got %0d want 1", rx_q.size() - rb); end
    endtask

    initial begin
        exp_dump = '{8'hA5, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33,
                     8'h44, 8'h44, 8'h55, 8'h55, 8'h66, 8'h66, 8'h77, 8'h77};
        set_regs();
        test_reset();
        test_full_dump();
        test_snapshot();
        test_busy_start();
        test_back_to_back();
        test_bit_timing();
        test_reset_midbyte();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
